// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver with a blanking guard between digits.
// The display buffer is double-buffered and swaps only at frame boundaries.
module seg7_scan_driver #(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYCLES   = 4,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BL = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BL);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // With no guard cycles every slot begins directly in SHOW
  localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_wrap;
  logic          frame_wrap;

  logic [N_DIGITS-1:0][3:0] shadow_hex;
  logic [N_DIGITS-1:0]      shadow_dp;
  logic [N_DIGITS-1:0][3:0] pend_hex;
  logic [N_DIGITS-1:0]      pend_dp;
  logic                     pend_valid;

  logic [N_DIGITS-1:0] sel_nxt;
  logic [7:0]          seg_nxt;
  logic [N_DIGITS-1:0] sel_on;
  logic [7:0]          seg_on;
  logic [3:0]          nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] r;
    unique case (h)
      4'h0: r = 7'h3F;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5B;
      4'h3: r = 7'h4F;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6D;
      4'h6: r = 7'h7D;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h6F;
      4'hA: r = 7'h77;
      4'hB: r = 7'h7C;
      4'hC: r = 7'h39;
      4'hD: r = 7'h5E;
      4'hE: r = 7'h79;
      4'hF: r = 7'h71;
    endcase
    return r;
  endfunction

  assign slot_wrap  = (cnt == CNT_MAX);
  assign frame_wrap = slot_wrap && (idx == IDX_MAX);
  assign frame_done = frame_wrap & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_START;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (slot_wrap) begin
      state_nxt = SLOT_START;
    end else if (state == BLANK && cnt == BLANK_LAST) begin
      state_nxt = SHOW;
    end
  end

  always_comb begin
    sel_on = '0;
    seg_on = '0;
    nib    = shadow_hex[idx];
    if (state == SHOW) begin
      sel_on[idx] = digit_en[idx];
      seg_on      = {shadow_dp[idx], hex7(nib)};
    end
    sel_nxt = sel_on ^ {N_DIGITS{SEL_INV}};
    seg_nxt = seg_on ^ {8{SEG_INV}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= {N_DIGITS{SEL_INV}};
      seg <= {8{SEG_INV}};
    end else begin
      sel <= sel_nxt;
      seg <= seg_nxt;
    end
  end

  // A load landing on the wrap cycle bypasses pending and shows next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_hex <= '0;
      shadow_dp  <= '0;
      pend_hex   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load) begin
        pend_hex   <= data;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
      if (frame_wrap) begin
        if (load) begin
          shadow_hex <= data;
          shadow_dp  <= dp_in;
        end else if (pend_valid) begin
          shadow_hex <= pend_hex;
          shadow_dp  <= pend_dp;
        end
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 8 digits, 4-cycle slots,
// 1 guard cycle, active-low select and segments.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        load;
  logic [7:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  int checks;
  int errors;

  seg7_scan_driver #(
    .N_DIGITS(8),
    .SCAN_DIV(4),
    .BLANK_CYCLES(1),
    .SEL_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .load(load),
    .sel(sel),
    .seg(seg),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_exp(input logic [3:0] h,
                                         input logic dp);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return ~{dp, g};
  endfunction

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // Checks one full frame starting right after a frame_done sample
  task automatic check_frame(input logic [31:0] d, input logic [7:0] dp,
                             input logic [7:0] en, input logic sync);
    int j;
    int ph;
    logic [7:0] oh;
    logic [3:0] nb;
    if (sync) wait_frame();
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      load = 1'b0;
      check("fd", {31'd0, frame_done}, {31'd0, n == 32});
      if (n >= 2) begin
        j  = (n - 2) / 4;
        ph = (n - 2) % 4;
        oh = 8'h01 << j;
        nb = d[4*j +: 4];
        if (ph == 0) begin
          check("sel_blank", {24'd0, sel}, 32'hFF);
          check("seg_blank", {24'd0, seg}, 32'hFF);
        end else begin
          check("sel_show", {24'd0, sel}, {24'd0, en[j] ? ~oh : 8'hFF});
          check("seg_show", {24'd0, seg}, {24'd0, seg_exp(nb, dp[j])});
        end
      end
    end
  endtask

  // First two slots after reset release, shadow all zero
  task automatic check_start();
    logic [7:0] es [8];
    logic [7:0] eg [8];
    es = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD};
    eg = '{8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hC0, 8'hC0, 8'hC0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("start_sel", {24'd0, sel}, {24'd0, es[i]});
      check("start_seg", {24'd0, seg}, {24'd0, eg[i]});
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    data     = '0;
    dp_in    = '0;
    digit_en = 8'hFF;
    load     = 1'b0;

    // 1: reset and blank buffer scan
    repeat (2) @(negedge clk);
    check("rst_sel", {24'd0, sel}, 32'hFF);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    check_start();
    check_frame(32'h0, 8'h00, 8'hFF, 1'b1);

    // 2: mid-frame load waits for the frame boundary
    data  = 32'h89ABCDEF;
    dp_in = 8'h01;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("mid_sel", {24'd0, sel}, 32'hFE);
    check("mid_seg", {24'd0, seg}, 32'hC0);
    check_frame(32'h89ABCDEF, 8'h01, 8'hFF, 1'b1);

    // 3: second load in a frame overwrites the first
    data  = 32'h11111111;
    dp_in = 8'h00;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    data = 32'h22222222;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_frame(32'h22222222, 8'h00, 8'hFF, 1'b1);

    // 4: load on the frame_done cycle shows in the very next frame
    wait_frame();
    data  = 32'h01234567;
    dp_in = 8'h80;
    load  = 1'b1;
    check_frame(32'h01234567, 8'h80, 8'hFF, 1'b0);

    // 5: disabled digits keep their slot but never select
    digit_en = 8'hF0;
    check_frame(32'h01234567, 8'h80, 8'hF0, 1'b1);
    digit_en = 8'hFF;

    // 6: async reset in the middle of digit 5
    wait_frame();
    repeat (23) @(negedge clk);
    check("pre_rst_sel", {24'd0, sel}, 32'hDF);
    check("pre_rst_seg", {24'd0, seg}, 32'hA4);
    rst = 1'b1;
    #1;
    check("async_sel", {24'd0, sel}, 32'hFF);
    check("async_seg", {24'd0, seg}, 32'hFF);
    check("async_fd", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_start();
    check_frame(32'h0, 8'h00, 8'hFF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
